mem_copy_master: RTL
====================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 7, per-channel address width; DATA_W, default 8, per-channel data width; SIZE_W, default 4, per-channel size field width.
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_port  input  1  one-cycle request to begin a copy.
REQ-005 src_addr, dst_addr, len  input  ADDR_W each  source base, destination base, byte count; sampled on accepted start_port.
REQ-006 done_port  output  1  one-cycle pulse at copy completion.
REQ-007 err_port  output  1  timeout abort flag; present only under MEMCPY_TIMEOUT_EN.
REQ-008 Mout_oe_ram, Mout_we_ram  output  2  read and write enables; bit 0 = channel 0, bit 1 = channel 1.
REQ-009 Mout_addr_ram  output  2*ADDR_W  channel 0 in [ADDR_W-1:0], channel 1 in the upper half.
REQ-010 Mout_Wdata_ram  output  2*DATA_W  write data, same channel packing.
REQ-011 Mout_data_ram_size  output  2*SIZE_W  access size in bits, same channel packing.
REQ-012 M_Rdata_ram  input  2*DATA_W  read data; valid in the cycle M_DataRdy is high for that channel.
REQ-013 M_DataRdy  input  2  per-channel access-complete strobe.

Function
REQ-014 Channel 0 SHALL carry only reads and channel 1 only writes; Mout_we_ram[0] and Mout_oe_ram[1] SHALL be held 0.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; reset forces IDLE.
REQ-016 IDLE: on start_port=1, latch src, dst and len, clear rd_cnt, wr_cnt and the FIFO; go to DONE if len=0, otherwise go to RUN.
REQ-017 start_port SHALL be ignored in RUN and DONE.
REQ-018 Read request: in RUN, Mout_oe_ram[0]=1 while rd_cnt<len and FIFO occupancy <2, with addr0=(src+rd_cnt) mod 2^ADDR_W.
REQ-019 A read request SHALL hold oe and address stable until M_DataRdy[0]=1; in that cycle push M_Rdata_ram[DATA_W-1:0] and increment rd_cnt.
REQ-020 Write request: in RUN, Mout_we_ram[1]=1 while the FIFO is non-empty, with addr1=(dst+wr_cnt) mod 2^ADDR_W and Wdata1=FIFO head.
REQ-021 A write request SHALL hold we, address and data stable until M_DataRdy[1]=1; in that cycle pop the FIFO and increment wr_cnt.
REQ-022 Mout_data_ram_size for a channel SHALL be DATA_W while that channel's enable is high, and 0 otherwise.
REQ-023 A simultaneous push and pop in one cycle SHALL be legal and leave occupancy unchanged.
REQ-024 Reads and writes SHALL overlap; the FIFO is exactly 2 entries deep.
REQ-025 RUN SHALL go to DONE in the cycle after the pop that makes wr_cnt equal len.
REQ-026 DONE: done_port=1 for exactly one cycle, then return to IDLE.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W; source/destination overlap is neither detected nor corrected.
REQ-028 M_DataRdy on a channel with no active request SHALL be ignored.

Reset
REQ-029 While reset=1: state=IDLE, counters and FIFO cleared, and every output (including err_port) driven 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately with no done_port pulse; the next start after release is serviced normally.

Configuration
REQ-031 With MEMCPY_TIMEOUT_EN defined: an 8-bit per-channel wait counter SHALL count cycles of an active request without M_DataRdy.
REQ-032 When a wait counter reaches 255 (under MEMCPY_TIMEOUT_EN): drop all enables, go to DONE, and pulse err_port together with done_port.
REQ-033 Without MEMCPY_TIMEOUT_EN: there is no counter and no err_port port, and a request waits indefinitely.

Structure
REQ-034 Package mem_copy_pkg SHALL hold ADDR_W, DATA_W and SIZE_W defaults, the state enum {IDLE, RUN, DONE} and the timeout limit constant 255.
REQ-035 The 2-entry FIFO SHALL be the sub-module mem_copy_fifo2: push, pop, data in, head out, count[1:0], synchronous clear.

Verification
REQ-036 Scenario: responder with read delay 2, write delay 1, src=0x10, dst=0x20, len=3, memory 0x10..0x12 = AA,BB,CC -> 0x20..0x22 = AA,BB,CC; exactly one done_port pulse; oe[0] and we[1] overlap in at least one cycle.
REQ-037 Scenario: len=0 start -> done_port in the 2nd cycle after start; no oe or we asserted.
REQ-038 Scenario: src=0x7E, dst=0x40, len=4 -> read addresses in order 0x7E, 0x7F, 0x00, 0x01; writes to 0x40..0x43.
REQ-039 Scenario: reset pulsed after 2 bytes written of len=5 -> all outputs 0 next cycle, no done_port; new start with len=1 completes correctly.
REQ-040 Scenario: start_port reasserted during RUN with different src -> ignored; original copy completes unchanged.
REQ-041 Scenario (MEMCPY_TIMEOUT_EN): M_DataRdy[0] tied 0, len=1 -> oe[0] held 255 cycles, then done_port=1 and err_port=1 in the same cycle.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_pkg
// Shared definitions for the mem_copy_master block: default channel widths,
// the copy FSM state type and the request timeout limit (used only when the
// design is built with MEMCPY_TIMEOUT_EN defined).
// -----------------------------------------------------------------------------
package mem_copy_pkg;

  localparam int MC_ADDR_W = 7;
  localparam int MC_DATA_W = 8;
  localparam int MC_SIZE_W = 4;

  // Number of stalled request cycles after which a copy is abandoned.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_copy_fifo2.sv
// -----------------------------------------------------------------------------
// mem_copy_fifo2
// Two-entry FIFO decoupling the read channel from the write channel.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   clear         : synchronous flush (new copy accepted)
//   push, din     : write din when not full
//   pop           : drop the head entry when not empty
//   head          : oldest entry (meaningful only when count != 0)
//   count[1:0]    : occupancy 0..2
// A push and a pop in the same cycle leave the occupancy unchanged.
// -----------------------------------------------------------------------------
module mem_copy_fifo2
  import mem_copy_pkg::*;
#(
  parameter int DATA_W = MC_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    do_push_s = push && (count_r != 2'd2);
    do_pop_s  = pop  && (count_r != 2'd0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
// Copies len bytes from src_addr to dst_addr over a two-channel memory port.
// Channel 0 only reads, channel 1 only writes; a 2-entry FIFO lets the two
// channels overlap. Addresses wrap modulo 2^ADDR_W.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   start_port             : one-cycle start request (honoured only in IDLE)
//   src_addr/dst_addr/len  : copy parameters, sampled on an accepted start
//   done_port              : one-cycle completion pulse
//   err_port               : timeout abort flag (MEMCPY_TIMEOUT_EN builds only)
//   Mout_oe_ram/we_ram     : per-channel read/write enables (bit n = channel n)
//   Mout_addr_ram          : per-channel address, channel 0 in the low half
//   Mout_Wdata_ram         : per-channel write data, same packing
//   Mout_data_ram_size     : per-channel access size in bits, same packing
//   M_Rdata_ram            : per-channel read data
//   M_DataRdy              : per-channel access-complete strobe
// Optional feature: define MEMCPY_TIMEOUT_EN to abort a copy when a request
// stalls for TIMEOUT_LIMIT cycles; done_port and err_port then pulse together.
// -----------------------------------------------------------------------------
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W,
  parameter int SIZE_W = MC_SIZE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_port,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W-1:0]   len,
  output logic                done_port,
`ifdef MEMCPY_TIMEOUT_EN
  output logic                err_port,
`endif
  output logic [1:0]          Mout_oe_ram,
  output logic [1:0]          Mout_we_ram,
  output logic [2*ADDR_W-1:0] Mout_addr_ram,
  output logic [2*DATA_W-1:0] Mout_Wdata_ram,
  output logic [2*SIZE_W-1:0] Mout_data_ram_size,
  input  logic [2*DATA_W-1:0] M_Rdata_ram,
  input  logic [1:0]          M_DataRdy
);

  localparam logic [SIZE_W-1:0] ACC_SIZE = SIZE_W'(DATA_W);

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic [ADDR_W-1:0] wr_cnt_r;

  logic              accept_s;
  logic              rd_act_s;
  logic              wr_act_s;
  logic              push_s;
  logic              pop_s;
  logic              last_pop_s;
  logic              rd_to_s;
  logic              wr_to_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [1:0]        fifo_cnt_s;
  logic [DATA_W-1:0] fifo_head_s;

  // The upper half of the read data bus belongs to the write-only channel.
  logic              unused_rdata_s;
  assign unused_rdata_s = ^M_Rdata_ram[2*DATA_W-1:DATA_W];

`ifdef MEMCPY_TIMEOUT_EN
  logic [7:0]        rd_wait_r;
  logic [7:0]        wr_wait_r;
  logic              err_r;
`endif

  mem_copy_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (accept_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (M_Rdata_ram[DATA_W-1:0]),
    .head  (fifo_head_s),
    .count (fifo_cnt_s)
  );

  // Request qualification, handshakes and timeout detection.
  // Once raised, a request stays up until its strobe: only a push changes
  // rd_cnt and only a pop changes the FIFO head, and a pop never refills it.
  always_comb begin
    accept_s   = (state_r == IDLE) && start_port;
    rd_act_s   = (state_r == RUN) && (rd_cnt_r < len_r) && (fifo_cnt_s != 2'd2);
    wr_act_s   = (state_r == RUN) && (fifo_cnt_s != 2'd0);
    push_s     = rd_act_s && M_DataRdy[0];
    pop_s      = wr_act_s && M_DataRdy[1];
    last_pop_s = pop_s && ((wr_cnt_r + ADDR_W'(1)) == len_r);
    rd_addr_s  = src_r + rd_cnt_r;
    wr_addr_s  = dst_r + wr_cnt_r;
`ifdef MEMCPY_TIMEOUT_EN
    // Fire on the stalled cycle that brings the wait count to the limit.
    rd_to_s    = rd_act_s && !M_DataRdy[0] && (rd_wait_r == (TIMEOUT_LIMIT - 8'd1));
    wr_to_s    = wr_act_s && !M_DataRdy[1] && (wr_wait_r == (TIMEOUT_LIMIT - 8'd1));
`else
    rd_to_s    = 1'b0;
    wr_to_s    = 1'b0;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_port) begin
          state_next_s = (len == {ADDR_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_pop_s || rd_to_s || wr_to_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, latched copy parameters and progress counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      src_r    <= {ADDR_W{1'b0}};
      dst_r    <= {ADDR_W{1'b0}};
      len_r    <= {ADDR_W{1'b0}};
      rd_cnt_r <= {ADDR_W{1'b0}};
      wr_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        src_r    <= src_addr;
        dst_r    <= dst_addr;
        len_r    <= len;
        rd_cnt_r <= {ADDR_W{1'b0}};
        wr_cnt_r <= {ADDR_W{1'b0}};
      end else begin
        if (push_s) begin
          rd_cnt_r <= rd_cnt_r + ADDR_W'(1);
        end
        if (pop_s) begin
          wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
        end
      end
    end
  end

`ifdef MEMCPY_TIMEOUT_EN
  // Per-channel stall counters and the error flag shown during DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_wait_r <= 8'd0;
      wr_wait_r <= 8'd0;
      err_r     <= 1'b0;
    end else begin
      rd_wait_r <= (rd_act_s && !M_DataRdy[0]) ? rd_wait_r + 8'd1 : 8'd0;
      wr_wait_r <= (wr_act_s && !M_DataRdy[1]) ? wr_wait_r + 8'd1 : 8'd0;
      err_r     <= rd_to_s || wr_to_s;
    end
  end
`endif

  // Output drive; everything is forced low while reset is held.
  always_comb begin
    if (reset) begin
      Mout_oe_ram        = 2'b00;
      Mout_we_ram        = 2'b00;
      Mout_addr_ram      = {(2*ADDR_W){1'b0}};
      Mout_Wdata_ram     = {(2*DATA_W){1'b0}};
      Mout_data_ram_size = {(2*SIZE_W){1'b0}};
      done_port          = 1'b0;
`ifdef MEMCPY_TIMEOUT_EN
      err_port           = 1'b0;
`endif
    end else begin
      Mout_oe_ram        = {1'b0, rd_act_s};
      Mout_we_ram        = {wr_act_s, 1'b0};
      Mout_addr_ram      = {(wr_act_s ? wr_addr_s : {ADDR_W{1'b0}}),
                            (rd_act_s ? rd_addr_s : {ADDR_W{1'b0}})};
      Mout_Wdata_ram     = {(wr_act_s ? fifo_head_s : {DATA_W{1'b0}}), {DATA_W{1'b0}}};
      Mout_data_ram_size = {(wr_act_s ? ACC_SIZE : {SIZE_W{1'b0}}),
                            (rd_act_s ? ACC_SIZE : {SIZE_W{1'b0}})};
      done_port          = (state_r == DONE);
`ifdef MEMCPY_TIMEOUT_EN
      err_port           = err_r && (state_r == DONE);
`endif
    end
  end

endmodule
